barrel_shift_seq: RTL and testbench
===================================

# barrel_shift_seq

Parametrised, multi-cycle shift/rotate engine: the sequential successor to the team's combinational 16-bit left/right shifter. It loads an operand on a start pulse, applies up to STEP bit positions per clock under a small FSM, and reports completion with a one-cycle `done` pulse. Five modes are supported: logical left/right, arithmetic right, and rotate left/right. It sits in the datapath wherever a wide shift does not fit a single cycle, or where area matters more than latency.

## Interface
Parameters:
- WIDTH, default 16: operand/result width, ≥ 2.
- STEP, default 1: maximum bit positions shifted per clock, 1..WIDTH.
- SW, default 16: width of SHIFT_VALUE.

Ports:
- Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-low.
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous active-low reset.
- start, in, 1: request a new operation; sampled only in IDLE or DONE.
- DATA, in, WIDTH: operand, captured on accepted start.
- SHIFT_VALUE, in, SW: shift amount, captured on accepted start.
- MODE, in, 3: 000 LSR, 001 LSL, 010 ASR, 011 ROR, 100 ROL; 101–111 behave as LSR.
- busy, out, 1: high while in SHIFT.
- done, out, 1: one-cycle pulse in DONE.
- Reg_Shift_Out, out, WIDTH: working/result register.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- Effective count eff is computed on accept:
  - rotate modes: SHIFT_VALUE mod WIDTH.
  - other modes: min(SHIFT_VALUE, WIDTH).
- On accepted start:
  - result register <= DATA; cnt <= eff; mode latched.
  - Next state is DONE if eff == 0, else SHIFT.
- SHIFT, each clock:
  - k = min(STEP, cnt); the register shifts/rotates by k per the latched mode; cnt <= cnt − k.
  - When cnt − k == 0, next state is DONE.
- Fill rules:
  - LSL/LSR fill with 0.
  - ASR fills with the captured operand's MSB; the sign is held constant for the whole operation.
  - Rotates wrap bits end-around.
  - eff == WIDTH gives all-zeros (logical) or all-sign (ASR).
- DONE lasts one cycle, then:
  - start high → accept the new operation (back-to-back, no IDLE bubble).
  - else → IDLE.
- start in SHIFT is ignored; there is no queueing.
- Once `done` pulses, Reg_Shift_Out holds the final result until the next accepted start.
- During SHIFT, Reg_Shift_Out shows intermediate values. Consumers sample it only with `done`.
- MODE, DATA and SHIFT_VALUE changes after accept have no effect on the operation in flight.

## Timing
- Reset values: state IDLE, Reg_Shift_Out = 0, cnt = 0, busy = 0, done = 0.
- Reset asserted mid-operation aborts immediately to those values. There is no done pulse for the aborted operation.
- Let N = ceil(eff / STEP). With start sampled at edge E0:
  - shifts occur at edges E1..EN;
  - `done` is high during the cycle after EN;
  - start-to-done latency is N+1 cycles;
  - eff == 0 gives done in the cycle after E0, with result = DATA.
- busy is high from the cycle after E0 through the cycle after EN−1, i.e. N cycles. busy and done are never high together.
- Back-to-back throughput is one operation per N+1 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- WIDTH=16, STEP=1: LSR 0xF0F0 by 4 -> Reg_Shift_Out = 0x0F0F; done exactly 5 cycles after start; busy high 4 cycles.
- ASR 0x8000 by 20 (eff clamps to 16) -> 0xFFFF; done at cycle 17. LSL 0x1234 by 16 -> 0x0000.
- ROL 0x8001 by 17 (eff = 1) -> 0x0003 at cycle 2. ROR 0x0001 by 0 -> 0x0001, done at cycle 1, busy never high.
- STEP=4 instance: LSL 0x0001 by 7 -> 0x0080; N = 2 (4 then 3), done at cycle 3.
- Handshake:
  - start pulsed during SHIFT with different DATA -> ignored; the original result is produced.
  - start held high in DONE -> second operation accepted with no IDLE cycle.
- Reset:
  - rst low in the middle of a 10-bit LSR -> outputs 0, state IDLE, no done.
  - A new start after release completes normally.

Source files
------------

// File: rtl/barrel_shift_seq.sv
// barrel_shift_seq: multi-cycle shift/rotate engine, up to STEP bit positions per clock
// Ports: clk, rst (async active-low); start/DATA/SHIFT_VALUE/MODE load an operation
// in IDLE or DONE; busy is high in SHIFT, done pulses for one cycle in DONE;
// Reg_Shift_Out is the working register and holds the result after done.
// MODE: 0 LSR, 1 LSL, 2 ASR, 3 ROR, 4 ROL, 5-7 LSR.
module barrel_shift_seq #(
  parameter int WIDTH = 16,
  parameter int STEP = 1,
  parameter int SW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] DATA,
  input  logic [SW-1:0]    SHIFT_VALUE,
  input  logic [2:0]       MODE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Reg_Shift_Out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int XW = SW > CW ? SW : CW;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, eff, k;
  logic [2:0] mode_q;
  logic sign, accept, rot_in;
  logic [XW-1:0] sv_x, w_x;
  logic [WIDTH-1:0] shifted, fill;
  // Rotates wrap the count modulo WIDTH; other modes saturate at WIDTH so the
  // register ends all-zero or all-sign.
  always_comb begin
    sv_x = XW'(SHIFT_VALUE);
    w_x = XW'(WIDTH);
    rot_in = MODE == 3'd3 || MODE == 3'd4;
    eff = CW'(rot_in ? sv_x % w_x : (sv_x > w_x ? w_x : sv_x));
    accept = start && state != SHIFT;
    k = cnt > CW'(STEP) ? CW'(STEP) : cnt;
    fill = sign ? ~({WIDTH{1'b1}} >> k) : '0;
    shifted = mode_q == 3'd1 ? Reg_Shift_Out << k :
              mode_q == 3'd2 ? (Reg_Shift_Out >> k) | fill :
              mode_q == 3'd3 ? (Reg_Shift_Out >> k) | (Reg_Shift_Out << (CW'(WIDTH) - k)) :
              mode_q == 3'd4 ? (Reg_Shift_Out << k) | (Reg_Shift_Out >> (CW'(WIDTH) - k)) :
              Reg_Shift_Out >> k;
    state_n = accept ? (eff == '0 ? DONE : SHIFT) :
              state == SHIFT ? (cnt == k ? DONE : SHIFT) : IDLE;
    busy = state == SHIFT;
    done = state == DONE;
  end
  // The sign is captured from the operand so ASR fill stays constant across steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      mode_q <= '0;
      sign <= 1'b0;
      Reg_Shift_Out <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        Reg_Shift_Out <= DATA;
        cnt <= eff;
        mode_q <= MODE;
        sign <= DATA[WIDTH-1];
      end else if (state == SHIFT) begin
        Reg_Shift_Out <= shifted;
        cnt <= cnt - k;
      end
    end
  end
endmodule

// File: tb/tb_barrel_shift_seq.sv
// tb_barrel_shift_seq: STEP=1 and STEP=4 instances driven in parallel, checked against an arithmetic model
module tb_barrel_shift_seq;
  logic clk, rst, start;
  logic [15:0] data, shift_value;
  logic [2:0] mode;
  logic busy1, done1, busy4, done4;
  logic [15:0] q1, q4;
  int total, passed;

  typedef struct {
    logic [15:0] r1, r4;
    int c1, c4, b1, b4, d1, d4;
    bit overlap;
  } obs_t;

  typedef struct {
    logic [15:0] d, sv;
    logic [2:0] m;
    logic [15:0] r;
    int c1, c4;
  } vec_t;

  vec_t vt [11] = '{
    '{16'hF0F0, 16'd4,  3'd0, 16'h0F0F, 5,  2},
    '{16'h8000, 16'd20, 3'd2, 16'hFFFF, 17, 5},
    '{16'h1234, 16'd16, 3'd1, 16'h0000, 17, 5},
    '{16'h8001, 16'd17, 3'd4, 16'h0003, 2,  2},
    '{16'h0001, 16'd0,  3'd3, 16'h0001, 1,  1},
    '{16'h0001, 16'd7,  3'd1, 16'h0080, 8,  3},
    '{16'h7FFF, 16'd3,  3'd2, 16'h0FFF, 4,  2},
    '{16'h8000, 16'd15, 3'd7, 16'h0001, 16, 5},
    '{16'h1234, 16'd4,  3'd3, 16'h4123, 5,  2},
    '{16'h9000, 16'd5,  3'd2, 16'hFC80, 6,  3},
    '{16'h0001, 16'd15, 3'd4, 16'h8000, 16, 5}
  };

  barrel_shift_seq #(.WIDTH(16), .STEP(1), .SW(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .DATA(data), .SHIFT_VALUE(shift_value),
    .MODE(mode), .busy(busy1), .done(done1), .Reg_Shift_Out(q1));
  barrel_shift_seq #(.WIDTH(16), .STEP(4), .SW(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .DATA(data), .SHIFT_VALUE(shift_value),
    .MODE(mode), .busy(busy4), .done(done4), .Reg_Shift_Out(q4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] sv,
                                        input logic [2:0] m, output int eff);
    logic [31:0] dd, tmp;
    logic signed [31:0] s;
    dd = {d, d};
    s = {{16{d[15]}}, d};
    eff = (m == 3'd3 || m == 3'd4) ? int'(sv % 16'd16) : (sv > 16'd16 ? 16 : int'(sv));
    tmp = dd << eff;
    case (m)
      3'd1: return 16'(32'(d) << eff);
      3'd2: return 16'(s >>> eff);
      3'd3: return 16'(dd >> eff);
      3'd4: return tmp[31:16];
      default: return 16'(32'(d) >> eff);
    endcase
  endfunction

  task automatic do_op(input logic [15:0] d, input logic [15:0] sv, input logic [2:0] m,
                       input int pulse_at, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    data = d; shift_value = sv; mode = m; start = 1'b1;
    for (int c = 1; c <= 40 && (o.c1 == 0 || o.c4 == 0); c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == pulse_at) begin
        data = 16'hFFFF; shift_value = 16'd1; mode = 3'd1;
      end else begin
        data = 16'($urandom); shift_value = 16'($urandom); mode = 3'($urandom);
      end
      if (busy1) o.b1++;
      if (busy4) o.b4++;
      if ((busy1 && done1) || (busy4 && done4)) o.overlap = 1'b1;
      if (done1) o.d1++;
      if (done4) o.d4++;
      if (done1 && o.c1 == 0) begin o.c1 = c; o.r1 = q1; end
      if (done4 && o.c4 == 0) begin o.c4 = c; o.r4 = q4; end
    end
    start = 1'b0;
    @(negedge clk);
    if (done1) o.d1++;
    if (done4) o.d4++;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; data = 16'hA5A5; shift_value = 16'd3; mode = 3'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({q1, q4} !== 32'h0 || {busy1, done1, busy4, done4} !== 4'b0)
      $display("FAIL reset_state got q1=%h q4=%h bd=%b exp 0", q1, q4, {busy1, done1, busy4, done4});
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_directed;
    obs_t o;
    foreach (vt[i]) begin
      do_op(vt[i].d, vt[i].sv, vt[i].m, 0, o);
      total++; if (o.r1 !== vt[i].r) $display("FAIL dir%0d_r1 got %h exp %h", i, o.r1, vt[i].r); else passed++;
      total++; if (o.r4 !== vt[i].r) $display("FAIL dir%0d_r4 got %h exp %h", i, o.r4, vt[i].r); else passed++;
      total++; if (o.c1 != vt[i].c1) $display("FAIL dir%0d_lat1 got %0d exp %0d", i, o.c1, vt[i].c1); else passed++;
      total++; if (o.c4 != vt[i].c4) $display("FAIL dir%0d_lat4 got %0d exp %0d", i, o.c4, vt[i].c4); else passed++;
      total++; if (o.b1 != vt[i].c1 - 1) $display("FAIL dir%0d_busy1 got %0d exp %0d", i, o.b1, vt[i].c1 - 1); else passed++;
      total++; if (o.b4 != vt[i].c4 - 1) $display("FAIL dir%0d_busy4 got %0d exp %0d", i, o.b4, vt[i].c4 - 1); else passed++;
      total++;
      if (o.overlap || o.d1 != 1 || o.d4 != 1)
        $display("FAIL dir%0d_pulse got overlap=%0d d1=%0d d4=%0d exp 0/1/1", i, o.overlap, o.d1, o.d4);
      else passed++;
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic [15:0] d, sv, e;
    logic [2:0] m;
    int eff, n1, n4;
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      m = 3'($urandom_range(0, 7));
      sv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      e = model(d, sv, m, eff);
      n1 = eff;
      n4 = (eff + 3) / 4;
      do_op(d, sv, m, 0, o);
      total++; if (o.r1 !== e) $display("FAIL rnd%0d_r1 m=%0d d=%h sv=%0d got %h exp %h", i, m, d, sv, o.r1, e); else passed++;
      total++; if (o.r4 !== e) $display("FAIL rnd%0d_r4 m=%0d d=%h sv=%0d got %h exp %h", i, m, d, sv, o.r4, e); else passed++;
      total++; if (o.c1 != n1 + 1 || o.b1 != n1) $display("FAIL rnd%0d_timing1 got lat=%0d busy=%0d exp %0d/%0d", i, o.c1, o.b1, n1 + 1, n1); else passed++;
      total++; if (o.c4 != n4 + 1 || o.b4 != n4) $display("FAIL rnd%0d_timing4 got lat=%0d busy=%0d exp %0d/%0d", i, o.c4, o.b4, n4 + 1, n4); else passed++;
      total++;
      if (o.overlap || o.d1 != 1 || o.d4 != 1)
        $display("FAIL rnd%0d_pulse got overlap=%0d d1=%0d d4=%0d exp 0/1/1", i, o.overlap, o.d1, o.d4);
      else passed++;
    end
  endtask

  task automatic test_ignore_start;
    obs_t o;
    do_op(16'hF0F0, 16'd8, 3'd0, 2, o);
    total++; if (o.r1 !== 16'h00F0) $display("FAIL ignore_r1 got %h exp 00f0", o.r1); else passed++;
    total++; if (o.r4 !== 16'h00F0) $display("FAIL ignore_r4 got %h exp 00f0", o.r4); else passed++;
    total++; if (o.c1 != 9 || o.c4 != 3) $display("FAIL ignore_lat got %0d/%0d exp 9/3", o.c1, o.c4); else passed++;
  endtask

  task automatic test_back_to_back;
    int c1, c4;
    logic [15:0] r1, r4;
    c1 = 0; c4 = 0; r1 = '0; r4 = '0;
    @(negedge clk);
    data = 16'h8001; shift_value = 16'd17; mode = 3'd4; start = 1'b1;
    @(negedge clk);
    data = 16'hF0F0; shift_value = 16'd4; mode = 3'd0;
    total++; if ({busy1, busy4} !== 2'b11) $display("FAIL b2b_busy_a got %b exp 11", {busy1, busy4}); else passed++;
    @(negedge clk);
    total++;
    if ({done1, done4} !== 2'b11 || q1 !== 16'h0003 || q4 !== 16'h0003)
      $display("FAIL b2b_first got done=%b q1=%h q4=%h exp 11 0003 0003", {done1, done4}, q1, q4);
    else passed++;
    @(negedge clk);
    start = 1'b0;
    total++; if ({busy1, busy4, done1, done4} !== 4'b1100) $display("FAIL b2b_no_bubble got %b exp 1100", {busy1, busy4, done1, done4}); else passed++;
    for (int c = 4; c <= 30 && (c1 == 0 || c4 == 0); c++) begin
      @(negedge clk);
      if (done1 && c1 == 0) begin c1 = c; r1 = q1; end
      if (done4 && c4 == 0) begin c4 = c; r4 = q4; end
    end
    total++; if (c1 != 7 || c4 != 4) $display("FAIL b2b_second_lat got %0d/%0d exp 7/4", c1, c4); else passed++;
    total++; if (r1 !== 16'h0F0F || r4 !== 16'h0F0F) $display("FAIL b2b_second_r got %h/%h exp 0f0f", r1, r4); else passed++;
  endtask

  task automatic test_reset_mid;
    obs_t o;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    data = 16'hFFFF; shift_value = 16'd10; mode = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({q1, q4} !== 32'h0 || {busy1, done1, busy4, done4} !== 4'b0)
      $display("FAIL rst_mid_async got q1=%h q4=%h bd=%b exp 0", q1, q4, {busy1, done1, busy4, done4});
    else passed++;
    repeat (12) begin
      @(negedge clk);
      if (done1 || done4 || busy1 || busy4) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL rst_mid_quiet got activity=1 exp 0"); else passed++;
    rst = 1'b1;
    do_op(16'hABCD, 16'd10, 3'd0, 0, o);
    total++; if (o.r1 !== 16'h002A || o.r4 !== 16'h002A) $display("FAIL rst_after_r got %h/%h exp 002a", o.r1, o.r4); else passed++;
    total++; if (o.c1 != 11 || o.c4 != 4) $display("FAIL rst_after_lat got %0d/%0d exp 11/4", o.c1, o.c4); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
